regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters.
- Source A: the in-order pipeline (MEM/WB result).
- Source B: long-latency units (divider, multi-cycle load), buffered in a small FIFO.
The block also keeps a scoreboard of registers with outstanding source-B writes, so the decode stage can stall reads of those registers. It sits between the writeback sources and the register file's we/waddr/wdata inputs.

Parameters:
DATA_W, 32, data width (matches `RegBus)
ADDR_W, 5, register address width (matches `RegNumLog2)
B_DEPTH, 2, source-B FIFO depth in entries; power of two, >=2

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
a_valid  in  1  source A has a write
a_ready  out  1  source A write accepted this cycle (combinational)
a_waddr  in  ADDR_W  source A destination register
a_wdata  in  DATA_W  source A data
b_valid  in  1  source B has a write
b_ready  out  1  FIFO not full (combinational)
b_waddr  in  ADDR_W  source B destination register
b_wdata  in  DATA_W  source B data
sb_set  in  1  decode dispatched an op to a long-latency unit
sb_addr  in  ADDR_W  its destination register
q_raddr1  in  ADDR_W  scoreboard query 1
q_busy1  out  1  q_raddr1 has a pending B write (combinational)
q_raddr2  in  ADDR_W  scoreboard query 2
q_busy2  out  1  q_raddr2 has a pending B write (combinational)
we  out  1  regfile write enable (registered)
waddr  out  ADDR_W  regfile write address (registered)
wdata  out  DATA_W  regfile write data (registered)
b_count  out  log2(B_DEPTH)+1  FIFO occupancy (registered)

Behaviour:
- Reset (rst=1 at posedge): we=0, waddr=0, wdata=0, b_count=0, FIFO pointers 0, all busy bits 0, last_grant=B (so A wins the first contention).
- FIFO:
  - Push when b_valid && b_ready; b_ready = (b_count != B_DEPTH).
  - Pointers wrap modulo B_DEPTH.
  - A push and a pop in the same cycle on a full FIFO is not allowed, because b_ready is 0 when full.
  - A push and a pop in the same cycle on a non-full FIFO leaves b_count unchanged.
- Arbitration, once per cycle:
  - Candidates are A (a_valid, unbuffered) and the FIFO head (b_count!=0).
  - Only one candidate: grant it.
  - Both: grant the source opposite to last_grant.
  - last_grant updates only on a cycle with a grant.
  - a_ready = grant_A. Pop the FIFO on grant_B.
- Output register:
  - On a grant, at the next posedge: we=1 and waddr/wdata take the granted entry. Otherwise we=0, and waddr/wdata hold their previous values.
  - A grant with address 0 completes its handshake, pops the FIFO if it is a B entry, and drives we=0.
- Latency:
  - A write with no contention: a_valid at cycle t, we=1 at t+1.
  - B write: pushed at t, earliest grant t+1, we=1 at t+2.
  - Worst case under continuous A traffic: B head is granted within 2 cycles of reaching the head.
- Scoreboard:
  - busy[1..2^ADDR_W-1]; busy[0] is constant 0.
  - sb_set with sb_addr!=0 sets busy[sb_addr] at the posedge.
  - busy[waddr_B] is cleared at the same posedge that registers the B write into we/waddr/wdata. The regfile's write-bypass covers a read in the cycle we=1.
  - sb_set and a clear to the same address in the same cycle: set wins.
  - A writes never touch the scoreboard.
  - q_busyN = busy[q_raddrN], combinational; a query of address 0 returns 0.
- Reset mid-operation: FIFO contents are discarded, busy bits are cleared, and no write is emitted at the reset edge (we=0 the following cycle).

Test Plan:
1. Reset, then A only: a_valid=1, a_waddr=3, a_wdata=0x11 at cycle 1 -> a_ready=1 at cycle 1; we=1, waddr=3, wdata=0x11 at cycle 2; we=0 at cycle 3.
2. Contention: A writes x4=0xA each cycle; B pushes x5=0xB at cycle 1 -> writes alternate: x4 (cycle 2), x5 (cycle 3), x4 (cycle 4); FIFO empties, b_count=0 at cycle 3.
3. FIFO full: three B pushes while A saturates and last_grant=B -> b_count=2 and b_ready=0 on the third; push ignored; drain order is FIFO.
4. Scoreboard: sb_set x7 at cycle 1 -> q_busy1=1 for q_raddr1=7 from cycle 2; B write x7=0x77 accepted -> busy clears at the edge where we=1, waddr=7; sb_set x7 with a clear in the same cycle -> busy stays 1.
5. x0 handling: B write to x0 -> b_ready/pop complete, we stays 0; sb_set x0 -> q_busy for address 0 stays 0.
6. Mid-stream reset: b_count=2 and busy[9]=1, assert rst for one cycle -> b_count=0, busy all 0, we=0 next cycle, no stale FIFO write afterwards.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the decode scoreboard queries and the register-file write port.
// The arbiter connects through the slave modport; the master modport is the view from the surrounding pipeline.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int B_DEPTH = 2
);
    localparam int CNT_W = $clog2(B_DEPTH) + 1;

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_waddr;
    logic [DATA_W-1:0] a_wdata;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_waddr;
    logic [DATA_W-1:0] b_wdata;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic [ADDR_W-1:0] q_raddr1;
    logic              q_busy1;
    logic [ADDR_W-1:0] q_raddr2;
    logic              q_busy2;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [CNT_W-1:0]  b_count;

    modport slave (
        input  a_valid, a_waddr, a_wdata,
        input  b_valid, b_waddr, b_wdata,
        input  sb_set, sb_addr, q_raddr1, q_raddr2,
        output a_ready, b_ready, q_busy1, q_busy2,
        output we, waddr, wdata, b_count
    );

    modport master (
        output a_valid, a_waddr, a_wdata,
        output b_valid, b_waddr, b_wdata,
        output sb_set, sb_addr, q_raddr1, q_raddr2,
        input  a_ready, b_ready, q_busy1, q_busy2,
        input  we, waddr, wdata, b_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the in-order pipeline (A) and a FIFO of long-latency results (B),
// and tracks registers with outstanding B writes so decode can stall on them.
module regfile_wb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int B_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(B_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic {GRANT_A, GRANT_B} grant_e;

    grant_e            last_grant;
    logic [ADDR_W-1:0] fifo_addr [B_DEPTH];
    logic [DATA_W-1:0] fifo_data [B_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [NREGS-1:0]  busy;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              full;
    logic              b_pending;
    logic              push;
    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign full      = (count == CNT_W'(B_DEPTH));
    assign b_pending = (count != '0);
    assign push      = bus.b_valid && !full;
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // Under contention the source that did not win last time is granted.
    assign grant_a  = bus.a_valid && (!b_pending || last_grant == GRANT_B);
    assign grant_b  = b_pending && (!bus.a_valid || last_grant == GRANT_A);
    assign sel_addr = grant_a ? bus.a_waddr : head_addr;
    assign sel_data = grant_a ? bus.a_wdata : head_data;

    assign bus.a_ready = grant_a;
    assign bus.b_ready = !full;
    assign bus.q_busy1 = busy[bus.q_raddr1];
    assign bus.q_busy2 = busy[bus.q_raddr2];
    assign bus.we      = we_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;
    assign bus.b_count = count;

    // NOTE: FIFO storage has no reset; count and the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.b_waddr;
            fifo_data[wr_ptr] <= bus.b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= GRANT_B;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (grant_b)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, grant_b})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (grant_a)
                last_grant <= GRANT_A;
            else if (grant_b)
                last_grant <= GRANT_B;
            // A granted write to x0 still completes its handshake but never reaches the register file.
            we_q <= (grant_a || grant_b) && (sel_addr != '0);
            if (grant_a || grant_b) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
            end
        end
    end

    // NOTE: the set is scheduled after the clear, so a same-cycle set and clear of one register leaves it busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (grant_b)
                busy[head_addr] <= 1'b0;
            if (bus.sb_set && bus.sb_addr != '0)
                busy[bus.sb_addr] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, A-only, contention, FIFO full, scoreboard, x0 and mid-stream reset.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .B_DEPTH(2)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .B_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid  = 1'b0;
        bus.a_waddr  = '0;
        bus.a_wdata  = '0;
        bus.b_valid  = 1'b0;
        bus.b_waddr  = '0;
        bus.b_wdata  = '0;
        bus.sb_set   = 1'b0;
        bus.sb_addr  = '0;
        bus.q_raddr1 = '0;
        bus.q_raddr2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        settle();

        // Reset state
        check("rst_we", bus.we, 0);
        check("rst_waddr", bus.waddr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_count", bus.b_count, 0);
        check("rst_b_ready", bus.b_ready, 1);
        check("rst_busy", bus.q_busy1, 0);

        // 1: A only
        bus.a_valid = 1'b1; bus.a_waddr = 5'd3; bus.a_wdata = 32'h11;
        settle();
        check("t1_a_ready", bus.a_ready, 1);
        tick();
        check("t1_we", bus.we, 1);
        check("t1_waddr", bus.waddr, 3);
        check("t1_wdata", bus.wdata, 32'h11);
        bus.a_valid = 1'b0;
        tick();
        check("t1_we_off", bus.we, 0);

        // 2: contention, last_grant=B after reset
        do_reset();
        bus.a_valid = 1'b1; bus.a_waddr = 5'd4; bus.a_wdata = 32'hA;
        bus.b_valid = 1'b1; bus.b_waddr = 5'd5; bus.b_wdata = 32'hB;
        settle();
        check("t2_c1_a_ready", bus.a_ready, 1);
        check("t2_c1_b_ready", bus.b_ready, 1);
        tick();
        check("t2_c2_waddr", bus.waddr, 4);
        check("t2_c2_count", bus.b_count, 1);
        bus.b_valid = 1'b0;
        settle();
        check("t2_c2_a_ready", bus.a_ready, 0);
        tick();
        check("t2_c3_we", bus.we, 1);
        check("t2_c3_waddr", bus.waddr, 5);
        check("t2_c3_wdata", bus.wdata, 32'hB);
        check("t2_c3_count", bus.b_count, 0);
        settle();
        check("t2_c3_a_ready", bus.a_ready, 1);
        tick();
        check("t2_c4_waddr", bus.waddr, 4);
        check("t2_c4_wdata", bus.wdata, 32'hA);
        bus.a_valid = 1'b0;
        tick();

        // 3: FIFO full while A saturates
        do_reset();
        bus.a_valid = 1'b1; bus.a_waddr = 5'd1; bus.a_wdata = 32'hAA;
        bus.b_valid = 1'b1; bus.b_waddr = 5'd10; bus.b_wdata = 32'h100;
        settle();
        check("t3_c1_a_ready", bus.a_ready, 1);
        tick();
        check("t3_c1_waddr", bus.waddr, 1);
        bus.b_waddr = 5'd11; bus.b_wdata = 32'h101;
        settle();
        check("t3_c2_a_ready", bus.a_ready, 0);
        tick();
        check("t3_c2_waddr", bus.waddr, 10);
        check("t3_c2_wdata", bus.wdata, 32'h100);
        check("t3_c2_count", bus.b_count, 1);
        bus.b_waddr = 5'd12; bus.b_wdata = 32'h102;
        settle();
        check("t3_c3_b_ready", bus.b_ready, 1);
        tick();
        check("t3_c3_waddr", bus.waddr, 1);
        check("t3_c3_count", bus.b_count, 2);
        bus.b_waddr = 5'd13; bus.b_wdata = 32'h103;
        settle();
        check("t3_full_b_ready", bus.b_ready, 0);
        check("t3_c4_a_ready", bus.a_ready, 0);
        tick();
        check("t3_c4_waddr", bus.waddr, 11);
        check("t3_c4_wdata", bus.wdata, 32'h101);
        check("t3_c4_count", bus.b_count, 1);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        tick();
        check("t3_c5_waddr", bus.waddr, 12);
        check("t3_c5_wdata", bus.wdata, 32'h102);
        check("t3_c5_count", bus.b_count, 0);
        tick();
        check("t3_no_x13_we", bus.we, 0);

        // 4: scoreboard
        do_reset();
        bus.sb_set = 1'b1; bus.sb_addr = 5'd7; bus.q_raddr1 = 5'd7; bus.q_raddr2 = 5'd8;
        settle();
        check("t4_busy_before", bus.q_busy1, 0);
        tick();
        bus.sb_set = 1'b0;
        settle();
        check("t4_busy_set", bus.q_busy1, 1);
        check("t4_other_clear", bus.q_busy2, 0);
        bus.b_valid = 1'b1; bus.b_waddr = 5'd7; bus.b_wdata = 32'h77;
        tick();
        bus.b_valid = 1'b0;
        settle();
        check("t4_busy_queued", bus.q_busy1, 1);
        check("t4_we_queued", bus.we, 0);
        tick();
        check("t4_we", bus.we, 1);
        check("t4_waddr", bus.waddr, 7);
        check("t4_wdata", bus.wdata, 32'h77);
        check("t4_busy_cleared", bus.q_busy1, 0);
        bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
        bus.b_valid = 1'b1; bus.b_waddr = 5'd7; bus.b_wdata = 32'h78;
        tick();
        bus.b_valid = 1'b0;
        tick();
        bus.sb_set = 1'b0;
        settle();
        check("t4_set_wins_we", bus.wdata, 32'h78);
        check("t4_set_wins_busy", bus.q_busy1, 1);

        // 5: x0 handling
        do_reset();
        bus.b_valid = 1'b1; bus.b_waddr = 5'd0; bus.b_wdata = 32'h55;
        settle();
        check("t5_b_ready", bus.b_ready, 1);
        tick();
        bus.b_valid = 1'b0;
        check("t5_count_push", bus.b_count, 1);
        tick();
        check("t5_pop_count", bus.b_count, 0);
        check("t5_b_x0_we", bus.we, 0);
        bus.a_valid = 1'b1; bus.a_waddr = 5'd0; bus.a_wdata = 32'h66;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd0; bus.q_raddr1 = 5'd0;
        settle();
        check("t5_a_x0_ready", bus.a_ready, 1);
        tick();
        bus.a_valid = 1'b0; bus.sb_set = 1'b0;
        settle();
        check("t5_a_x0_we", bus.we, 0);
        check("t5_busy_x0", bus.q_busy1, 0);

        // 6: mid-stream reset
        do_reset();
        bus.q_raddr1 = 5'd9;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
        bus.a_valid = 1'b1; bus.a_waddr = 5'd2; bus.a_wdata = 32'h22;
        bus.b_valid = 1'b1; bus.b_waddr = 5'd20; bus.b_wdata = 32'h200;
        tick();
        bus.sb_set = 1'b0;
        bus.b_waddr = 5'd21; bus.b_wdata = 32'h201;
        tick();
        bus.b_waddr = 5'd22; bus.b_wdata = 32'h202;
        tick();
        bus.b_valid = 1'b0;
        settle();
        check("t6_pre_count", bus.b_count, 2);
        check("t6_pre_busy", bus.q_busy1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.a_valid = 1'b0;
        settle();
        check("t6_rst_we", bus.we, 0);
        check("t6_rst_count", bus.b_count, 0);
        check("t6_rst_busy", bus.q_busy1, 0);
        check("t6_rst_b_ready", bus.b_ready, 1);
        tick();
        check("t6_no_stale_we1", bus.we, 0);
        tick();
        check("t6_no_stale_we2", bus.we, 0);
        check("t6_count_after", bus.b_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
